fp16_psum_norm: RTL and testbench
=================================

Name: fp16_psum_norm

Overview:
- Output end of the fp16 accumulation path. Takes the unnormalized partial-sum buffer format held inside the accumulator: sign, 5-bit biased exponent and 13-bit magnitude with carry/cancellation headroom.
- Produces IEEE-754 binary16 results: normalized, round-to-nearest-even, with overflow to infinity and flush-to-zero on underflow.
- 2-stage pipeline with valid/ready handshake; sits between the accumulator's done-sum and the result writeback.

Parameters:
- IN_MANT_W, 13, input magnitude width; bit 10 is the unit position, bits above 10 are carry headroom; must be 12..16.
- FRAC_W, 10, output fraction width; fixed for fp16, not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_sign  in  1  psum sign
- in_exp  in  5  psum biased exponent (bias 15)
- in_mant  in  IN_MANT_W  unsigned psum magnitude; value = (-1)^sign * mant * 2^(exp-15-10)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  fp16 result
- out_ovf  out  1  result overflowed (inf or saturated)
- out_udf  out  1  nonzero input flushed to zero

Behaviour:
- Reset values (async, rst_n low): out_valid=0, out_data=16'h0000, out_ovf=0, out_udf=0, and all internal stage valids=0. in_ready is then 1.
- Pipeline advance: adv = ~out_valid | out_ready, with in_ready = adv.
  - The transfer on the input side occurs when in_valid & in_ready.
  - The transfer on the output side occurs when out_valid & out_ready.
  - When adv=0, all stages hold; out_data and flags stay stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles, from the input transfer edge to out_valid asserted. Throughput is 1 per cycle when out_ready is held high.
- Stage 1 (registered):
  - Leading-one position p (0..IN_MANT_W-1) of in_mant.
  - Zero flag when in_mant==0.
  - Signed 7-bit e_new = in_exp + p - 10.
  - Carry sign and mant forward.
- Stage 2 (registered into outputs):
  - p>10: shift right by p-10. Guard = last shifted-out bit; sticky = OR of the rest. Round up when guard & (sticky | lsb).
  - p<=10: shift left by 10-p; no rounding.
  - If rounding carries the significand to 2.0: fraction=0, e_new+1.
- Result classes, in priority order:
  - zero: out_data=16'h0000, always +0, flags 0.
  - e_new>=31 after rounding: {sign,5'h1F,10'h0}, out_ovf=1.
  - e_new<=0: {sign,15'h0}, out_udf=1.
  - otherwise: {sign, e_new[4:0], frac[9:0]}.
- Input exponent 0 has no special meaning; it is treated numerically. No NaN is ever produced; inputs never encode inf/NaN.
- Flags are qualified by out_valid and cleared to 0 when a new beat loads.
- Reset mid-operation drops all in-flight beats; no output is produced for them.
- Simultaneous output accept and input accept in the same cycle is legal and required at full rate.

Optional Feature:
- Macro FP16_NORM_SAT_EN.
- Defined: overflow saturates to max finite {sign,15'h7BFF}, i.e. 16'h7BFF or 16'hFBFF; out_ovf is still 1.
- Undefined: overflow produces signed infinity 16'h7C00 / 16'hFC00.

Test Plan:
- Exact and carry cases, out_ready=1:
  - sign0 exp15 mant 0x400 -> 16'h3C00, 2 cycles later.
  - exp15 mant 0x800 -> 16'h4000.
- RNE tie: exp15 mant 0xC03 -> 16'h4202. Separately, exp15 mant 0x801 -> tie with even lsb rounds down -> 16'h4000.
- Cancellation, zero and underflow:
  - exp20 mant 0x001 -> 16'h2800.
  - sign1 mant 0 -> 16'h0000.
  - exp5 mant 0x008 -> 16'h0000, out_udf=1.
- Overflow: exp30 mant 0x1000 -> 16'h7C00 with out_ovf=1. With FP16_NORM_SAT_EN defined -> 16'h7BFF.
- Backpressure:
  - Stream 4 beats back-to-back; drop out_ready for 3 cycles after the first result.
  - Required: out_data held stable, in_ready=0 while stalled.
  - No beat lost or duplicated; order preserved; full rate resumes when out_ready returns.
- Reset with 2 beats in flight -> out_valid=0 next cycle. After release, a new beat exp15 mant 0x400 yields only 16'h3C00.

Source files
------------

// File: rtl/fp16_psum_norm_if.sv
// fp16_psum_norm_if: handshake bundle around the psum normalizer.
//   in_*  : psum beat from the accumulator (valid/ready), sign/exp/mant
//   out_* : fp16 result toward writeback (valid/ready), data + ovf/udf flags
// slave modport is the normalizer's view; master is the driver/sink side.
interface fp16_psum_norm_if #(
  parameter int IN_MANT_W = 13
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [4:0]           in_exp;
  logic [IN_MANT_W-1:0] in_mant;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          out_data;
  logic                 out_ovf;
  logic                 out_udf;

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_udf
  );

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_udf
  );
endinterface

// File: rtl/fp16_psum_norm.sv
// fp16_psum_norm: normalizes an unnormalized accumulator psum
// (sign, 5b biased exp, IN_MANT_W-bit magnitude with unit at bit 10) into
// IEEE binary16 with round-to-nearest-even, overflow to inf and
// flush-to-zero. Two register stages, valid/ready, full rate.
// Ports:
//   clk, rst_n : clock (rising), async active-low reset
//   io         : fp16_psum_norm_if.slave (in_valid/in_ready/in_sign/in_exp/
//                in_mant, out_valid/out_ready/out_data/out_ovf/out_udf)
// Options:
//   FP16_NORM_SAT_EN : overflow saturates to +/-max finite instead of +/-inf.
// IN_MANT_W must be 12..16; FRAC_W is fixed at 10 for fp16.
module fp16_psum_norm #(
  parameter int IN_MANT_W = 13,
  parameter int FRAC_W    = 10
) (
  input logic             clk,
  input logic             rst_n,
  fp16_psum_norm_if.slave io
);
  localparam int STAGES = 2;
  localparam int PW     = 4;          // leading-one index, up to bit 15
  localparam int SW     = FRAC_W + 2; // carry + hidden + fraction

`ifdef FP16_NORM_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic adv;
  logic [STAGES:1] vld_pipe_q, vld_pipe_d;

  // stage 1
  logic                 s1_sign_q, s1_sign_d;
  logic                 s1_zero_q, s1_zero_d;
  logic [PW-1:0]        s1_p_q, s1_p_d;
  logic signed [6:0]    s1_e_q, s1_e_d;
  logic [IN_MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [PW-1:0]        lead;

  // stage 2 / outputs
  logic [15:0]          out_data_q, out_data_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_udf_q, out_udf_d;
  logic [PW-1:0]        sh;
  logic [IN_MANT_W-1:0] low_mask;
  logic                 guard, sticky, rnd;
  logic [SW-1:0]        sig;
  logic signed [6:0]    e_fin;
  logic [FRAC_W-1:0]    frac;
  logic                 unused_hidden;

  // Whole pipe stalls together whenever the output register is blocked.
  assign adv          = ~vld_pipe_q[STAGES] | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe_q[STAGES];
  assign io.out_data  = out_data_q;
  assign io.out_ovf   = out_ovf_q;
  assign io.out_udf   = out_udf_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_sign_d  = s1_sign_q;
    s1_zero_d  = s1_zero_q;
    s1_p_d     = s1_p_q;
    s1_e_d     = s1_e_q;
    s1_mant_d  = s1_mant_q;
    lead       = '0;
    for (int i = 0; i < IN_MANT_W; i++)
      if (io.in_mant[i]) lead = PW'(i);
    if (adv) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], io.in_valid};
      if (io.in_valid) begin
        s1_sign_d = io.in_sign;
        s1_zero_d = (io.in_mant == '0);
        s1_p_d    = lead;
        // exponent of the normalized value before rounding; may go <=0 or >=31
        s1_e_d    = 7'({2'b00, io.in_exp}) + 7'({3'b000, lead}) - 7'(FRAC_W);
        s1_mant_d = io.in_mant;
      end
    end
  end

  always_comb begin
    sh       = '0;
    low_mask = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    rnd      = 1'b0;
    e_fin    = s1_e_q;
    if (s1_p_q > PW'(FRAC_W)) begin
      sh       = s1_p_q - PW'(FRAC_W);
      guard    = s1_mant_q[sh - PW'(1)];
      low_mask = (IN_MANT_W'(1) << (sh - PW'(1))) - IN_MANT_W'(1);
      sticky   = |(s1_mant_q & low_mask);
      rnd      = guard & (sticky | s1_mant_q[sh]);
      sig      = SW'(s1_mant_q >> sh) + SW'(rnd);
    end else begin
      sig      = SW'(s1_mant_q << (PW'(FRAC_W) - s1_p_q));
    end
    // rounding all-ones up leaves sig = 2.0, whose fraction bits are already 0
    if (sig[SW-1]) e_fin = s1_e_q + 7'sd1;
    frac          = sig[FRAC_W-1:0];
    unused_hidden = sig[FRAC_W]; // implied leading one, not stored in fp16

    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_udf_d  = out_udf_q;
    if (adv) begin
      out_data_d = '0;
      out_ovf_d  = 1'b0;
      out_udf_d  = 1'b0;
      if (vld_pipe_q[1] && !s1_zero_q) begin
        if (e_fin >= 7'sd31) begin
          out_data_d = {s1_sign_q, OVF_MAG};
          out_ovf_d  = 1'b1;
        end else if (e_fin <= 7'sd0) begin
          out_data_d = {s1_sign_q, 15'h0000};
          out_udf_d  = 1'b1;
        end else begin
          out_data_d = {s1_sign_q, e_fin[4:0], frac};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_p_q     <= '0;
      s1_e_q     <= '0;
      s1_mant_q  <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_udf_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_sign_q  <= s1_sign_d;
      s1_zero_q  <= s1_zero_d;
      s1_p_q     <= s1_p_d;
      s1_e_q     <= s1_e_d;
      s1_mant_q  <= s1_mant_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_udf_q  <= out_udf_d;
    end
  end
endmodule

// File: tb/tb_fp16_psum_norm.sv
// Bench for fp16_psum_norm: directed vectors with literal expectations, an
// arithmetic reference model feeding a scoreboard checked on every output
// transfer, backpressure and mid-flight reset scenarios.
module tb_fp16_psum_norm;
  localparam int MW = 13;
`ifdef FP16_NORM_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp16_psum_norm_if #(.IN_MANT_W(MW)) bus ();
  fp16_psum_norm #(.IN_MANT_W(MW)) dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int n0;
  logic [17:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // value = (-1)^s * m * 2^(e-25); returns {fp16, ovf, udf}
  function automatic logic [17:0] model(input logic s, input logic [4:0] e, input int m);
    int p, ex, sh, q, rem, half;
    if (m == 0) return 18'h0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    ex = int'(e) + p - 10;
    if (p > 10) begin
      sh   = p - 10;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == 2048) begin q = 1024; ex++; end
    end else begin
      q = m << (10 - p);
    end
    if (ex >= 31) return {s, OVF_MAG, 2'b10};
    if (ex <= 0)  return {s, 15'h0, 2'b01};
    return {s, 5'(ex), 10'(q), 2'b00};
  endfunction

  task automatic monitor();
    logic        held_v;
    logic [17:0] held_d, got, want;
    held_v = 1'b0;
    held_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        got = {bus.out_data, bus.out_ovf, bus.out_udf};
        if (held_v) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", 32'(got), 32'(held_d));
        end
        if (bus.out_valid && !bus.out_ready)
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %h want none", got);
          end else begin
            want = exp_q.pop_front();
            check("scoreboard", 32'(got), 32'(want));
          end
        end
        held_v = bus.out_valid && !bus.out_ready;
        held_d = got;
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.in_sign, bus.in_exp, int'(bus.in_mant)));
      end
    end
  endtask

  // Called just after a rising edge; returns just after the transfer edge.
  task automatic send(input logic s, input logic [4:0] e, input logic [MW-1:0] m);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_exp   = e;
    bus.in_mant  = m;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 100 cycles");
    end
  endtask

  task automatic run_vec(input string nm, input logic s, input logic [4:0] e,
                         input logic [MW-1:0] m, input logic [15:0] d,
                         input logic ovf, input logic udf);
    send(s, e, m);
    @(negedge clk);
    check({nm, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({nm, "_data"}, 32'(bus.out_data), 32'(d));
    check({nm, "_flags"}, 32'({bus.out_ovf, bus.out_udf}), 32'({ovf, udf}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = '0;
    bus.in_mant   = '0;
    bus.out_ready = 1'b1;
    fork
      monitor();
    join_none

    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_flags", 32'({bus.out_ovf, bus.out_udf}), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    check("model_pin_one", 32'(model(1'b0, 5'd15, 32'h400)), 32'({16'h3C00, 2'b00}));
    check("model_pin_rne", 32'(model(1'b0, 5'd15, 32'hC03)), 32'({16'h4202, 2'b00}));
    check("model_pin_even", 32'(model(1'b0, 5'd15, 32'h801)), 32'({16'h4000, 2'b00}));
    check("model_pin_udf", 32'(model(1'b0, 5'd5, 32'h008)), 32'({16'h0000, 2'b01}));

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_vec("one",       1'b0, 5'd15, 13'h0400, 16'h3C00, 1'b0, 1'b0);
    run_vec("carry",     1'b0, 5'd15, 13'h0800, 16'h4000, 1'b0, 1'b0);
    run_vec("rne_up",    1'b0, 5'd15, 13'h0C03, 16'h4202, 1'b0, 1'b0);
    run_vec("rne_even",  1'b0, 5'd15, 13'h0801, 16'h4000, 1'b0, 1'b0);
    run_vec("sticky_up", 1'b0, 5'd15, 13'h1003, 16'h4401, 1'b0, 1'b0);
    run_vec("tie_down",  1'b0, 5'd15, 13'h1002, 16'h4400, 1'b0, 1'b0);
    run_vec("round_2p0", 1'b0, 5'd15, 13'h0FFF, 16'h4400, 1'b0, 1'b0);
    run_vec("neg_one",   1'b1, 5'd15, 13'h0400, 16'hBC00, 1'b0, 1'b0);
    run_vec("cancel",    1'b0, 5'd20, 13'h0001, 16'h2800, 1'b0, 1'b0);
    run_vec("neg_zero",  1'b1, 5'd15, 13'h0000, 16'h0000, 1'b0, 1'b0);
    run_vec("udf",       1'b0, 5'd5,  13'h0008, 16'h0000, 1'b0, 1'b1);
    run_vec("min_norm",  1'b0, 5'd1,  13'h0400, 16'h0400, 1'b0, 1'b0);
    run_vec("exp0_num",  1'b0, 5'd0,  13'h0800, 16'h0400, 1'b0, 1'b0);
    run_vec("exp0_udf",  1'b1, 5'd0,  13'h0400, 16'h8000, 1'b0, 1'b1);
    run_vec("max_fin",   1'b0, 5'd29, 13'h0FFE, 16'h7BFF, 1'b0, 1'b0);
    run_vec("ovf",       1'b0, 5'd30, 13'h1000, {1'b0, OVF_MAG}, 1'b1, 1'b0);
    run_vec("ovf_round", 1'b1, 5'd29, 13'h0FFF, {1'b1, OVF_MAG}, 1'b1, 1'b0);

    // backpressure: 4 beats back-to-back, 3 stall cycles after first result
    n0 = n_out;
    fork
      begin
        send(1'b0, 5'd15, 13'h0400);
        send(1'b0, 5'd15, 13'h0800);
        send(1'b0, 5'd15, 13'h0C03);
        send(1'b1, 5'd20, 13'h0001);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = bus.out_valid;
        end
        check("bp_first_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_full_rate", 32'(bus.out_valid), 32'd1);
        end
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_count", 32'(n_out - n0), 32'd4);

    // reset with two beats in flight
    send(1'b0, 5'd15, 13'h0400);
    send(1'b0, 5'd15, 13'h0800);
    rst_n = 1'b0;
    #2;
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n0 = n_out;
    run_vec("post_rst", 1'b0, 5'd15, 13'h0400, 16'h3C00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_count", 32'(n_out - n0), 32'd1);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
